// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one serial "0110" detector between two word requesters.
// Each word is preceded by a run of '1' flush bits so the detector starts from idle.
module seq_det_sched #(
  parameter int W     = 8,
  parameter int CW    = $clog2(W+1),
  parameter int FLUSH = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid_i,
  input  logic [W-1:0]  req0_data_i,
  output logic          req0_ready_o,
  input  logic          req1_valid_i,
  input  logic [W-1:0]  req1_data_i,
  output logic          req1_ready_o,
  output logic          det_x_o,
  input  logic          det_y_i,
  output logic          rsp_valid_o,
  output logic          rsp_id_o,
  output logic [CW-1:0] rsp_count_o,
  input  logic          rsp_ready_i
);

  // state   | meaning
  // S_IDLE  | waiting for a request; grant decided combinationally
  // S_FLUSH | sending FLUSH '1' bits to park the detector
  // S_SHIFT | sending word MSB-first, counting det_y hits
  // S_RESP  | holding result until rsp_ready_i
  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_SHIFT, S_RESP} state_t;

  localparam int BCW = $clog2((W > FLUSH) ? W : FLUSH);

  state_t         state_q;
  logic [W-1:0]   shreg_q;
  logic [BCW-1:0] bitcnt_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic           id_q;
  logic           last_grant_q;
  logic           det_x_q;
  logic           rsp_valid_q;

  logic           gnt_id;
  logic [W-1:0]   gnt_data;
  logic           in_idle;
  logic           accept;
  logic           bit_tc;

  always_comb begin
    gnt_id       = req1_valid_i & (~req0_valid_i | ~last_grant_q);
    gnt_data     = gnt_id ? req1_data_i : req0_data_i;
    // rst gates the readies so nothing looks accepted while the block is held in reset
    in_idle      = rst & (state_q == S_IDLE);
    req0_ready_o = in_idle & req0_valid_i & ~gnt_id;
    req1_ready_o = in_idle & req1_valid_i & gnt_id;
    accept       = req0_ready_o | req1_ready_o;
    bit_tc       = (bitcnt_q == '0);
    cnt_d        = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      det_x_q      <= 1'b1;
      rsp_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          det_x_q <= 1'b1;
          if (accept) begin
            shreg_q      <= gnt_data;
            id_q         <= gnt_id;
            last_grant_q <= gnt_id;
            cnt_q        <= '0;
            bitcnt_q     <= BCW'(FLUSH - 1);
            state_q      <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (bit_tc) begin
            det_x_q  <= shreg_q[W-1];
            shreg_q  <= {shreg_q[W-2:0], 1'b0};
            bitcnt_q <= BCW'(W - 1);
            state_q  <= S_SHIFT;
          end else begin
            det_x_q  <= 1'b1;
            bitcnt_q <= bitcnt_q - 1'b1;
          end
        end
        S_SHIFT: begin
          if (det_y_i) cnt_q <= cnt_d;
          if (bit_tc) begin
            det_x_q     <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            det_x_q  <= shreg_q[W-1];
            shreg_q  <= {shreg_q[W-2:0], 1'b0};
            bitcnt_q <= bitcnt_q - 1'b1;
          end
        end
        S_RESP: begin
          det_x_q <= 1'b1;
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          det_x_q     <= 1'b1;
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign det_x_o     = det_x_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = id_q;
  assign rsp_count_o = cnt_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed bench for seq_det_sched with a behavioural overlapping "0110" Mealy detector.
module tb_seq_det_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       det_x, det_y;
  logic       rsp_valid, rsp_id, rsp_ready;
  logic [3:0] rsp_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_det_sched #(.W(8), .CW(4), .FLUSH(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid_i (req0_valid),
    .req0_data_i  (req0_data),
    .req0_ready_o (req0_ready),
    .req1_valid_i (req1_valid),
    .req1_data_i  (req1_data),
    .req1_ready_o (req1_ready),
    .det_x_o      (det_x),
    .det_y_i      (det_y),
    .rsp_valid_o  (rsp_valid),
    .rsp_id_o     (rsp_id),
    .rsp_count_o  (rsp_count),
    .rsp_ready_i  (rsp_ready)
  );

  // Detector: 0 none, 1 "0", 2 "01", 3 "011"; hit on 0 in state 3, overlapping.
  logic [1:0] dst;
  assign det_y = (dst == 2'd3) && !det_x;
  always @(posedge clk or negedge rst) begin
    if (!rst) dst <= 2'd0;
    else begin
      case (dst)
        2'd0: dst <= det_x ? 2'd0 : 2'd1;
        2'd1: dst <= det_x ? 2'd2 : 2'd1;
        2'd2: dst <= det_x ? 2'd3 : 2'd1;
        default: dst <= det_x ? 2'd0 : 2'd1;
      endcase
    end
  end

  // Drives one word on channel ch (caller at a negedge) and returns what came back.
  task automatic run_word(input logic ch, input logic [7:0] data,
                          output logic id, output logic [3:0] cnt,
                          output int lat, output logic [10:0] tr);
    int k;
    tr = '0; lat = -1; id = 1'b0; cnt = '0;
    if (ch) begin req1_data = data; req1_valid = 1'b1; end
    else    begin req0_data = data; req0_valid = 1'b1; end
    #1;
    k = 0;
    while (!(ch ? req1_ready : req0_ready) && k < 20) begin
      @(negedge clk); #1; k++;
    end
    if (k < 20) begin
      @(negedge clk);
      if (ch) req1_valid = 1'b0; else req0_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 40) begin
        tr = {tr[9:0], det_x};
        @(negedge clk);
        lat++;
      end
      id  = rsp_id;
      cnt = rsp_count;
    end else begin
      if (ch) req1_valid = 1'b0; else req0_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 8'h00; req1_data = 8'h00;
    @(negedge clk); @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got %0b exp 0", rsp_id); end
    checks++; if (rsp_count !== 4'd0) begin errors++; $display("FAIL reset_rsp_count got %0d exp 0", rsp_count); end
    checks++; if (det_x !== 1'b1) begin errors++; $display("FAIL reset_det_x got %0b exp 1", det_x); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
      begin errors++; $display("FAIL reset_readies got %0b%0b exp 00", req0_ready, req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    logic [7:0]  vd [5] = '{8'h36, 8'h66, 8'h06, 8'h00, 8'hFF};
    logic [3:0]  vc [5] = '{4'd2, 4'd2, 4'd1, 4'd0, 4'd0};
    logic        id;
    logic [3:0]  cnt;
    int          lat;
    logic [10:0] tr;
    for (int i = 0; i < 5; i++) begin
      run_word(1'b0, vd[i], id, cnt, lat, tr);
      checks++; if (lat !== 12) begin errors++; $display("FAIL single_lat word %h got %0d exp 12", vd[i], lat); end
      checks++; if (id !== 1'b0) begin errors++; $display("FAIL single_id word %h got %0b exp 0", vd[i], id); end
      checks++; if (cnt !== vc[i]) begin errors++; $display("FAIL single_count word %h got %0d exp %0d", vd[i], cnt, vc[i]); end
      if (i == 0) begin
        checks++; if (tr !== 11'b111_00110110)
          begin errors++; $display("FAIL single_det_x_seq got %b exp 11100110110", tr); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush_isolation();
    logic        id;
    logic [3:0]  cnt;
    int          lat;
    logic [10:0] tr;
    run_word(1'b0, 8'h01, id, cnt, lat, tr);
    checks++; if (lat !== 12 || cnt !== 4'd0) begin errors++; $display("FAIL flush_first got lat %0d count %0d exp 12 0", lat, cnt); end
    @(negedge clk);
    run_word(1'b0, 8'h80, id, cnt, lat, tr);
    checks++; if (lat !== 12 || cnt !== 4'd0) begin errors++; $display("FAIL flush_second got lat %0d count %0d exp 12 0", lat, cnt); end
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    logic       ids  [4];
    logic [3:0] cnts [4];
    int nresp = 0;
    int viol  = 0;
    for (int i = 0; i < 4; i++) begin ids[i] = 1'bx; cnts[i] = 'x; end
    rst = 1'b0;
    req0_data = 8'h36; req1_data = 8'h06;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 200 && nresp < 4; c++) begin
      #1;
      if (req0_ready && req1_ready) viol++;
      if (rsp_valid) begin ids[nresp] = rsp_id; cnts[nresp] = rsp_count; nresp++; end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (nresp !== 4) begin errors++; $display("FAIL arb_responses got %0d exp 4", nresp); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL arb_both_ready got %0d cycles exp 0", viol); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ids[i] !== 1'(i % 2) || cnts[i] !== ((i % 2) ? 4'd1 : 4'd2)) begin
        errors++;
        $display("FAIL arb_resp%0d got id %0b count %0d exp id %0d count %0d",
                 i, ids[i], cnts[i], i % 2, (i % 2) ? 1 : 2);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic        id;
    logic [3:0]  cnt;
    int          lat;
    logic [10:0] tr;
    int          bad = 0;
    rsp_ready = 1'b0;
    run_word(1'b1, 8'h66, id, cnt, lat, tr);
    checks++; if (lat !== 12 || id !== 1'b1 || cnt !== 4'd2)
      begin errors++; $display("FAIL bp_resp got lat %0d id %0b count %0d exp 12 1 2", lat, id, cnt); end
    req0_data = 8'h06; req0_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_count !== 4'd2 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || det_x !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
    rsp_ready = 1'b1; #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_same_cycle_grant got %0b exp 0", req0_ready); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b1)
      begin errors++; $display("FAIL bp_release got valid %0b ready0 %0b exp 0 1", rsp_valid, req0_ready); end
    req0_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift();
    logic        id;
    logic [3:0]  cnt;
    int          lat;
    logic [10:0] tr;
    int          k = 0;
    req0_data = 8'h06; req0_valid = 1'b1;
    #1;
    while (!req0_ready && k < 20) begin @(negedge clk); #1; k++; end
    checks++; if (k >= 20) begin errors++; $display("FAIL rst_mid_grant got timeout exp ready0"); end
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (det_x !== 1'b0) begin errors++; $display("FAIL rst_mid_pre_det_x got %0b exp 0", det_x); end
    rst = 1'b0; #1;
    checks++; if (rsp_valid !== 1'b0 || det_x !== 1'b1 || rsp_count !== 4'd0)
      begin errors++; $display("FAIL rst_mid_outputs got valid %0b det_x %0b count %0d exp 0 1 0", rsp_valid, det_x, rsp_count); end
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || rsp_valid !== 1'b0)
      begin errors++; $display("FAIL rst_mid_tie got r0 %0b r1 %0b valid %0b exp 1 0 0", req0_ready, req1_ready, rsp_valid); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    run_word(1'b1, 8'h36, id, cnt, lat, tr);
    checks++; if (lat !== 12 || id !== 1'b1 || cnt !== 4'd2)
      begin errors++; $display("FAIL rst_mid_after got lat %0d id %0b count %0d exp 12 1 2", lat, id, cnt); end
    @(negedge clk);
  endtask

  task automatic test_idle_line();
    int bad = 0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (det_x !== 1'b1 || rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_line got %0d bad cycles exp 0", bad); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_flush_isolation();
    test_arbitration();
    test_backpressure();
    test_reset_mid_shift();
    test_idle_line();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_sched.md
# seq_det_sched

Round-robin scheduler that shares one serial "0110" pattern detector between two word-level requesters. It accepts a W-bit word from a requester and flushes the detector into a known state. It then shifts the word MSB-first into the detector, counts detector hits, and returns the count tagged with the requester id. It sits between the parallel request sources and the single-bit detector (x in, Mealy y out, async active-low reset).

## Interface
- W, 8, word width in bits (W ≥ 4)
- CW, $clog2(W+1), width of the match count
- FLUSH, 3, number of '1' flush bits sent before each word (fixed; 3 ones drive the detector to its idle state from any state without a hit)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has a word
- req0_data  in  W  requester 0 word
- req0_ready  out  1  requester 0 word accepted this cycle (when valid & ready)
- req1_valid  in  1  requester 1 has a word
- req1_data  in  W  requester 1 word
- req1_ready  out  1  requester 1 word accepted this cycle
- det_x  out  1  serial bit to detector
- det_y  in  1  detector Mealy output, valid in the same cycle as det_x
- rsp_valid  out  1  result available
- rsp_id  out  1  requester that owns the result
- rsp_count  out  CW  number of detector hits during the word's shift phase
- rsp_ready  in  1  result consumer accepts

## Operation
- States: IDLE, FLUSH, SHIFT, RESP.
- IDLE:
  - Grant: if only one valid, that channel; if both valid, the channel ≠ last_grant.
  - reqN_ready = (state==IDLE) & granted==N. Ready depends combinationally on the valids, so requesters must not gate valid on ready.
  - On handshake: load shift reg, store id, clear counter, set last_grant=id, go FLUSH.
- FLUSH: FLUSH cycles with det_x=1; det_y ignored; then SHIFT.
- SHIFT:
  - W cycles; det_x = word bit W-1 first, bit 0 last.
  - Each cycle det_y=1 increments the counter (saturating at 2^CW-1; unreachable for legal W).
  - After bit 0, go RESP.
- RESP:
  - rsp_valid=1; rsp_id and rsp_count stable.
  - On rsp_ready=1, go IDLE; a new grant is possible next cycle.
- det_x=1 in IDLE and RESP (idle-high keeps the detector parked).
- No requests are accepted outside IDLE; both readies are 0 in FLUSH, SHIFT and RESP.
- Reset values: state IDLE, last_grant=1 (ch0 wins first tie), rsp_valid 0, rsp_id 0, rsp_count 0, det_x 1, shift reg 0. Both readies are forced 0 while rst is low.
- Reset mid-operation: the in-flight word and any pending result are dropped with no response; after release, behaviour is as after power-up.

## Timing
- Handshake in cycle T.
- FLUSH: T+1..T+3.
- SHIFT: T+4..T+3+W.
- rsp_valid first high: T+4+W (T+12 for W=8).
- Throughput with rsp_ready tied 1: one word per W+5 cycles (IDLE + FLUSH + W + RESP).
- Counter samples det_y on the rising edge ending each SHIFT cycle.
- det_x is driven from registered state and shift reg only (no input-to-det_x path).
- Backpressure: rsp_ready low holds RESP indefinitely; outputs must not change.
- Simultaneous rsp_ready and new request valid: the request is granted in the following IDLE cycle, not the same cycle.

## Test plan
- Single word: ch0 sends 0x36 (00110110) -> rsp_id 0, rsp_count 2, rsp_valid at T+12; det_x sequence 1,1,1,0,0,1,1,0,1,1,0. Ch0 sends 0x66 -> count 2, 0x06 -> 1, 0x00 -> 0, 0xFF -> 0.
- Flush isolation: ch0 sends 0x01 (detector ends in mid-pattern), then 0x80 -> counts 0 and 0. Without the flush the second word would count 1.
- Arbitration: both valid continuously from reset with ch0=0x36 and ch1=0x06 -> responses alternate id 0/count 2, id 1/count 1, id 0, id 1. Only the granted ready is ever high.
- Backpressure: hold rsp_ready=0 for 20 cycles after rsp_valid -> rsp_valid, id and count stable; both readies 0; det_x=1. Release -> one-cycle accept, then IDLE.
- Reset mid-SHIFT: assert rst at T+6 -> rsp_valid 0, det_x 1 immediately; after release, ch1 request with 0x36 -> id 1, count 2 (ch0 priority restored on ties).
- Idle line: no valids for 50 cycles -> det_x constant 1, rsp_valid 0, readies 0.
